gamepad_reader: RTL and testbench
=================================

GAMEPAD_READER -- requirements
Module: gamepad_reader

Interface
REQ-001 Parameter HALF_PERIOD, default 300, clk cycles per pad_clk half-period; SHALL be >= 4.
REQ-002 Parameter PLAYERS, default 2, number of serial pad ports read in parallel.
REQ-003 Port clk  input  1  single clock for all logic (clk_2x domain).
REQ-004 Port reset_n  input  1  asynchronous, active-low reset.
REQ-005 Port poll  input  1  single-cycle read request.
REQ-006 Port pad_data  input  PLAYERS  serial pad data, active-high (already inverted upstream), asynchronous.
REQ-007 Port pad_latch  output  1  pad latch strobe, registered.
REQ-008 Port pad_clk  output  1  pad shift clock, registered, idle high.
REQ-009 Port pad_btn  output  12*PLAYERS  button state, player p in bits [12p+11:12p].
REQ-010 Port busy  output  1  high while a read sequence is in progress.
REQ-011 Port valid  output  1  single-cycle pulse when pad_btn has been updated.

Function
REQ-012 States SHALL be IDLE, LATCH, CLK_LOW, CLK_HIGH, DONE.
REQ-013 IDLE: poll=1 -> LATCH next cycle; poll ignored in every other state (no queueing).
REQ-014 LATCH: pad_latch=1 for exactly 2*HALF_PERIOD cycles, pad_clk=1, then CLK_LOW.
REQ-015 CLK_LOW: pad_clk=0 for HALF_PERIOD cycles; synchronized pad_data of each player SHALL be sampled on the last CLK_LOW cycle into a 16-bit shift register, then CLK_HIGH.
REQ-016 CLK_HIGH: pad_clk=1 for HALF_PERIOD cycles; bit counter increments; after the 16th bit -> DONE, else CLK_LOW.
REQ-017 Bit order: k-th sampled bit (k=0..15) SHALL map to shift-register bit k; bits 12..15 (pad ID) discarded.
REQ-018 DONE (one cycle): all pad_btn players updated simultaneously from bits 0..11, valid=1, next state IDLE.
REQ-019 pad_btn SHALL hold its value between DONE cycles; never shows a partially shifted word.
REQ-020 busy SHALL be 1 in LATCH, CLK_LOW, CLK_HIGH, DONE; 0 in IDLE.
REQ-021 Latency: poll in cycle N -> pad_latch rises N+1 -> valid in cycle N+1+34*HALF_PERIOD.
REQ-022 Half-period counter width SHALL be $clog2(2*HALF_PERIOD+1); bit counter 4 bits, wraps 15->0 only on DONE.
REQ-023 pad_data SHALL pass through a 2-flop synchronizer before sampling (HALF_PERIOD>=4 covers its latency).
REQ-024 pad_latch and pad_clk SHALL be flop outputs, glitch-free.

Reset
REQ-025 reset_n=0 SHALL asynchronously force: state IDLE, pad_latch=0, pad_clk=1, pad_btn=0, busy=0, valid=0, counters and shift register 0.
REQ-026 Reset mid-sequence SHALL abort it with no valid pulse; pad_btn stays 0 until the next complete read.
REQ-027 Deassertion SHALL be synchronized externally; the first poll is accepted on the first clk edge with reset_n=1.

Structure
REQ-028 Shared package gamepad_pkg SHALL hold the state enum, PAD_BITS=16, BTN_BITS=12.
REQ-029 The synchronizer SHALL be one sub-module, sync_2ff, instantiated PLAYERS wide; all else in gamepad_reader.

Verification (HALF_PERIOD=4, PLAYERS=2, pad model shifts on pad_clk rising, loads on pad_latch high)
REQ-030 Poll with P1 word 16'h0A5C, P2 16'hF123 -> valid 137 cycles after poll; pad_btn = {12'h123, 12'hA5C}.
REQ-031 Second poll while busy=1 -> ignored; exactly 16 pad_clk falling edges and one valid pulse.
REQ-032 poll held high continuously -> back-to-back reads; one IDLE cycle between valid and the next pad_latch rise.
REQ-033 reset_n low during 8th CLK_LOW -> pad_clk=1, pad_latch=0, pad_btn=0 immediately; no valid pulse.
REQ-034 Pad data all ones (16'hFFFF) -> pad_btn per player = 12'hFFF; ID bits not visible.
REQ-035 Check every cycle: pad_latch=1 for exactly 8 cycles per read; pad_clk low/high phases exactly 4 cycles each.

Source files
------------

// File: rtl/gamepad_pkg.sv
// Shared types for the serial gamepad reader.
// Sequencer states and pad word geometry.
package gamepad_pkg;

  localparam int PAD_BITS = 16;
  localparam int BTN_BITS = 12;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    CLK_LOW,
    CLK_HIGH,
    DONE
  } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous pad data lines.
// One flop pair per bit, async active-low reset.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/gamepad_reader.sv
// Serial gamepad reader: latches all pads, shifts 16 bits each,
// and publishes the 12 button bits per player at once.
module gamepad_reader
  import gamepad_pkg::*;
#(
  parameter int HALF_PERIOD = 300,
  parameter int PLAYERS     = 2
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          poll,
  input  logic [PLAYERS-1:0]            pad_data,
  output logic                          pad_latch,
  output logic                          pad_clk,
  output logic [BTN_BITS*PLAYERS-1:0]   pad_btn,
  output logic                          busy,
  output logic                          valid
);

  localparam int CW = $clog2(2*HALF_PERIOD+1);
  localparam logic [CW-1:0] LATCH_END = CW'(2*HALF_PERIOD-1);
  localparam logic [CW-1:0] HALF_END  = CW'(HALF_PERIOD-1);
  localparam logic [3:0]    LAST_BIT  = 4'(PAD_BITS-1);

  state_t                        r_state;
  state_t                        w_next;
  logic [CW-1:0]                 r_cnt;
  logic [3:0]                    r_bit;
  logic [PAD_BITS-1:0]           r_shift [PLAYERS];
  logic [BTN_BITS*PLAYERS-1:0]   r_btn;
  logic                          r_latch;
  logic                          r_pclk;
  logic [PLAYERS-1:0]            w_sync;
  logic                          w_cnt_end;
  logic                          w_unused_id;

  sync_2ff #(
    .W (PLAYERS)
  ) u_sync (
    .i_clk   (clk),
    .i_rst_n (reset_n),
    .i_d     (pad_data),
    .o_q     (w_sync)
  );

  always_comb begin
    w_cnt_end = 1'b0;
    unique case (r_state)
      LATCH:    w_cnt_end = (r_cnt == LATCH_END);
      CLK_LOW,
      CLK_HIGH: w_cnt_end = (r_cnt == HALF_END);
      default:  w_cnt_end = 1'b0;
    endcase
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:     if (poll) w_next = LATCH;
      LATCH:    if (w_cnt_end) w_next = CLK_LOW;
      CLK_LOW:  if (w_cnt_end) w_next = CLK_HIGH;
      CLK_HIGH: begin
        if (w_cnt_end) begin
          w_next = (r_bit == LAST_BIT) ? DONE : CLK_LOW;
        end
      end
      DONE:     w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Phase counter restarts on every state change.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (w_next != r_state || r_state == IDLE) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bit <= '0;
    end else if (r_state == DONE) begin
      r_bit <= '0;
    end else if (r_state == CLK_HIGH && w_cnt_end && r_bit != LAST_BIT) begin
      r_bit <= r_bit + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int p = 0; p < PLAYERS; p++) begin
        r_shift[p] <= '0;
      end
    end else if (r_state == CLK_LOW && w_cnt_end) begin
      for (int p = 0; p < PLAYERS; p++) begin
        r_shift[p][r_bit] <= w_sync[p];
      end
    end
  end

  // Buttons change only when the full word is in, alongside valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_btn <= '0;
    end else if (w_next == DONE) begin
      for (int p = 0; p < PLAYERS; p++) begin
        r_btn[p*BTN_BITS +: BTN_BITS] <= r_shift[p][BTN_BITS-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_latch <= 1'b0;
      r_pclk  <= 1'b1;
    end else begin
      r_latch <= (w_next == LATCH);
      r_pclk  <= (w_next != CLK_LOW);
    end
  end

  always_comb begin
    w_unused_id = 1'b0;
    for (int p = 0; p < PLAYERS; p++) begin
      w_unused_id = w_unused_id ^ (^r_shift[p][PAD_BITS-1:BTN_BITS]);
    end
  end

  assign pad_latch = r_latch;
  assign pad_clk   = r_pclk;
  assign pad_btn   = r_btn;
  assign busy      = (r_state != IDLE);
  assign valid     = (r_state == DONE);

endmodule

// File: tb/tb_gamepad_reader.sv
// Directed bench for gamepad_reader with a two-pad shift model.
// HALF_PERIOD=4, PLAYERS=2.
module tb_gamepad_reader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        poll = 1'b0;
  logic [1:0]  pad_data;
  logic        pad_latch;
  logic        pad_clk;
  logic [23:0] pad_btn;
  logic        busy;
  logic        valid;

  int errors = 0;
  int checks = 0;

  gamepad_reader #(
    .HALF_PERIOD (4),
    .PLAYERS     (2)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .poll      (poll),
    .pad_data  (pad_data),
    .pad_latch (pad_latch),
    .pad_clk   (pad_clk),
    .pad_btn   (pad_btn),
    .busy      (busy),
    .valid     (valid)
  );

  always #5 clk = ~clk;

  // Pad model: loads on latch high, advances on pad_clk rising.
  logic [15:0] w0 = 16'h0;
  logic [15:0] w1 = 16'h0;
  logic [4:0]  idx = 5'd0;

  always @(posedge pad_latch or posedge pad_clk) begin
    if (pad_latch) idx = 5'd0;
    else idx = idx + 5'd1;
  end

  assign pad_data = {w1[idx[3:0]], w0[idx[3:0]]};

  // Per-cycle phase monitor.
  int  lat_run = 0;
  int  lo_run = 0;
  int  hi_run = 0;
  int  bad = 0;
  int  falls = 0;
  int  nlatch = 0;
  int  valids = 0;
  logic prev_pclk = 1'b1;
  logic hi_armed = 1'b0;

  always @(negedge clk) begin
    if (!reset_n) begin
      lat_run = 0;
      lo_run = 0;
      hi_run = 0;
      hi_armed = 1'b0;
      prev_pclk = 1'b1;
    end else begin
      if (pad_latch) begin
        lat_run++;
      end else if (lat_run != 0) begin
        if (lat_run != 8) bad++;
        lat_run = 0;
        nlatch++;
      end
      if (!pad_clk) begin
        if (prev_pclk) begin
          falls++;
          if (hi_armed && hi_run != 4) bad++;
          lo_run = 0;
        end
        lo_run++;
      end else begin
        if (!prev_pclk) begin
          if (lo_run != 4) bad++;
          hi_armed = 1'b1;
          hi_run = 0;
        end
        hi_run++;
      end
      if (pad_latch) hi_armed = 1'b0;
      if (valid) valids++;
      prev_pclk = pad_clk;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_to_valid(input int lim, output int n,
                              output logic [23:0] pre);
    n = 1;
    pre = pad_btn;
    while (!valid && n < lim) begin
      pre = pad_btn;
      tick();
      n++;
    end
  endtask

  int          n;
  logic [23:0] pre;
  int          f0, v0, l0, b0;

  initial begin
    repeat (3) tick();
    chk("rst_latch", 32'(pad_latch), 32'd0);
    chk("rst_pclk",  32'(pad_clk),   32'd1);
    chk("rst_btn",   32'(pad_btn),   32'd0);
    chk("rst_busy",  32'(busy),      32'd0);
    chk("rst_valid", 32'(valid),     32'd0);
    reset_n = 1'b1;
    repeat (2) tick();

    // Basic read and latency.
    w0 = 16'h0A5C;
    w1 = 16'hF123;
    f0 = falls; v0 = valids; l0 = nlatch; b0 = bad;
    poll = 1'b1;
    tick();
    poll = 1'b0;
    chk("t1_latch", 32'(pad_latch), 32'd1);
    chk("t1_busy",  32'(busy),      32'd1);
    run_to_valid(300, n, pre);
    chk("t1_valid",   32'(valid),   32'd1);
    chk("t1_latency", 32'(n),       32'd137);
    chk("t1_pre_btn", 32'(pre),     32'h000000);
    chk("t1_btn",     32'(pad_btn), 32'h123A5C);
    tick();
    chk("t1_valid_lo", 32'(valid), 32'd0);
    chk("t1_busy_lo",  32'(busy),  32'd0);
    repeat (3) tick();
    chk("t1_falls",  32'(falls - f0),  32'd16);
    chk("t1_valids", 32'(valids - v0), 32'd1);
    chk("t1_latchn", 32'(nlatch - l0), 32'd1);
    chk("t1_phases", 32'(bad - b0),    32'd0);

    // Poll while busy is ignored.
    w0 = 16'h5A5A;
    w1 = 16'h0F0F;
    f0 = falls; v0 = valids; l0 = nlatch; b0 = bad;
    poll = 1'b1;
    tick();
    poll = 1'b0;
    repeat (20) tick();
    poll = 1'b1;
    tick();
    poll = 1'b0;
    run_to_valid(300, n, pre);
    chk("t2_valid",   32'(valid),   32'd1);
    chk("t2_latency", 32'(n),       32'd116);
    chk("t2_pre_btn", 32'(pre),     32'h123A5C);
    chk("t2_btn",     32'(pad_btn), 32'hF0FA5A);
    repeat (40) tick();
    chk("t2_busy",   32'(busy),          32'd0);
    chk("t2_falls",  32'(falls - f0),    32'd16);
    chk("t2_valids", 32'(valids - v0),   32'd1);
    chk("t2_latchn", 32'(nlatch - l0),   32'd1);
    chk("t2_phases", 32'(bad - b0),      32'd0);

    // Poll held high: back-to-back reads.
    w0 = 16'h1234;
    w1 = 16'h8765;
    f0 = falls; v0 = valids; b0 = bad;
    poll = 1'b1;
    tick();
    run_to_valid(300, n, pre);
    chk("t3_valid1", 32'(valid),   32'd1);
    chk("t3_btn1",   32'(pad_btn), 32'h765234);
    tick();
    chk("t3_gap_latch", 32'(pad_latch), 32'd0);
    chk("t3_gap_busy",  32'(busy),      32'd0);
    tick();
    chk("t3_relatch", 32'(pad_latch), 32'd1);
    w0 = 16'hFFFF;
    w1 = 16'hFFFF;
    run_to_valid(300, n, pre);
    poll = 1'b0;
    chk("t3_valid2",  32'(valid),   32'd1);
    chk("t3_latency2", 32'(n),      32'd137);
    chk("t3_btn_ones", 32'(pad_btn), 32'hFFFFFF);
    repeat (20) tick();
    chk("t3_idle",   32'(busy),        32'd0);
    chk("t3_falls",  32'(falls - f0),  32'd32);
    chk("t3_valids", 32'(valids - v0), 32'd2);
    chk("t3_phases", 32'(bad - b0),    32'd0);

    // Reset during the 8th low phase.
    w0 = 16'h0001;
    w1 = 16'h0002;
    v0 = valids;
    poll = 1'b1;
    tick();
    poll = 1'b0;
    repeat (65) tick();
    chk("t4_in_low", 32'(pad_clk), 32'd0);
    reset_n = 1'b0;
    #1;
    chk("t4_pclk",  32'(pad_clk),   32'd1);
    chk("t4_latch", 32'(pad_latch), 32'd0);
    chk("t4_btn",   32'(pad_btn),   32'd0);
    chk("t4_busy",  32'(busy),      32'd0);
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (150) tick();
    chk("t4_no_valid", 32'(valids - v0), 32'd0);
    chk("t4_btn_hold", 32'(pad_btn),     32'd0);

    // First poll accepted on the first edge after reset release.
    reset_n = 1'b0;
    tick();
    w0 = 16'hF800;
    w1 = 16'h07FF;
    reset_n = 1'b1;
    poll = 1'b1;
    tick();
    poll = 1'b0;
    chk("t5_latch", 32'(pad_latch), 32'd1);
    run_to_valid(300, n, pre);
    chk("t5_valid",   32'(valid),   32'd1);
    chk("t5_latency", 32'(n),       32'd137);
    chk("t5_btn",     32'(pad_btn), 32'h7FF800);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
